// File: rtl/reg_lcd_pkg.sv
// Shared types and constants for the register-map LCD viewer.
// No logic, no latency, no backpressure.
package reg_lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_SNAP,
      ST_L1_ADDR,
      ST_L1_CHARS,
      ST_L2_ADDR,
      ST_L2_CHARS,
      ST_WAIT
   } lcd_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } wr_phase_t;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_0     = 8'h30;
   localparam logic [7:0] ASC_A     = 8'h41;
   localparam logic [7:0] ASC_B     = 8'h42;
   localparam logic [7:0] ASC_C     = 8'h43;
   localparam logic [7:0] ASC_D     = 8'h44;
   localparam logic [7:0] ASC_V     = 8'h56;
   localparam logic [7:0] ASC_Z     = 8'h5A;

   // A zero-length interval is meaningless for the LCD; run it as one cycle.
   function automatic int unsigned cyc_min1(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return ASC_0 + {4'h0, n};
      else
         return ASC_A + {4'h0, n} - 8'd10;
   endfunction

endpackage

// File: rtl/reg_lcd_display_writer.sv
// One HD44780 byte write: SETUP (1) -> PULSE (E_PULSE) -> HOLD (cmd or clear wait).
// Accepts start when idle or in the last HOLD cycle, so writes chain back to back.
module lcd_byte_writer
   import reg_lcd_pkg::*;
#(
   parameter int unsigned E_PULSE_CYC    = 25,
   parameter int unsigned CMD_WAIT_CYC   = 2500,
   parameter int unsigned CLEAR_WAIT_CYC = 100000,
   parameter int unsigned CNT_W          = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] wr_byte,
   input  logic       wr_rs,
   input  logic       long_wait,
   output logic       busy,
   output logic       done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(cyc_min1(E_PULSE_CYC) - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(cyc_min1(CMD_WAIT_CYC) - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(cyc_min1(CLEAR_WAIT_CYC) - 1);

   wr_phase_t        phase;
   logic [CNT_W-1:0] cnt;
   logic             long_q;
   logic             accept;

   assign done   = (phase == PH_HOLD) && (cnt == '0);
   assign busy   = (phase != PH_IDLE);
   assign accept = start && ((phase == PH_IDLE) || done);

   // lcd_e is its own flop so the strobe never glitches on a phase decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= PH_IDLE;
         cnt      <= '0;
         long_q   <= 1'b0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
      end else if (accept) begin
         phase    <= PH_SETUP;
         cnt      <= '0;
         long_q   <= long_wait;
         lcd_rs   <= wr_rs;
         lcd_data <= wr_byte;
      end else begin
         case (phase)
            PH_SETUP: begin
               phase <= PH_PULSE;
               cnt   <= PULSE_LAST;
               lcd_e <= 1'b1;
            end
            PH_PULSE: begin
               if (cnt == '0) begin
                  phase <= PH_HOLD;
                  lcd_e <= 1'b0;
                  cnt   <= long_q ? CLEAR_LAST : CMD_LAST;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            PH_HOLD: begin
               if (cnt == '0)
                  phase <= PH_IDLE;
               else
                  cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/reg_lcd_display.sv
// Snapshots reg_a..reg_d/flags and redraws them as hex text on a 16x2 HD44780 LCD.
// Frame = 34 chained byte writes then REFRESH_CYC idle; the LCD bus has no backpressure.
module reg_lcd_display
   import reg_lcd_pkg::*;
#(
   parameter int unsigned POWERUP_CYC    = 750000,
   parameter int unsigned E_PULSE_CYC    = 25,
   parameter int unsigned CMD_WAIT_CYC   = 2500,
   parameter int unsigned CLEAR_WAIT_CYC = 100000,
   parameter int unsigned REFRESH_CYC    = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] reg_a,
   input  logic [7:0] reg_b,
   input  logic [7:0] reg_c,
   input  logic [7:0] reg_d,
   input  logic [7:0] flags,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       frame_done
);

   localparam int unsigned PWR_N   = cyc_min1(POWERUP_CYC);
   localparam int unsigned REF_N   = cyc_min1(REFRESH_CYC);
   localparam int unsigned MAX_CYC = max2(max2(PWR_N, REF_N),
                                          max2(cyc_min1(CLEAR_WAIT_CYC),
                                               max2(cyc_min1(E_PULSE_CYC), cyc_min1(CMD_WAIT_CYC))));
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_N - 1);
   localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_N - 1);

   lcd_state_t       state, state_nxt;
   logic [3:0]       idx, idx_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_nxt;
   logic             fd_nxt;
   logic [7:0]       sh_a, sh_b, sh_c, sh_d;
   logic [2:0]       sh_flags;

   logic             wr_go, wr_start, wr_busy, wr_done, wr_rs, long_wait;
   logic [7:0]       wr_byte;
   logic             unused_flags;

   assign unused_flags = ^flags[7:3];
   assign lcd_rw       = 1'b0;

   function automatic logic [7:0] line1_char(input logic [3:0] i, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c);
      logic [7:0] ch;
      case (i)
         4'd0:    ch = ASC_A;
         4'd2:    ch = hex_ascii(a[7:4]);
         4'd3:    ch = hex_ascii(a[3:0]);
         4'd5:    ch = ASC_B;
         4'd7:    ch = hex_ascii(b[7:4]);
         4'd8:    ch = hex_ascii(b[3:0]);
         4'd10:   ch = ASC_C;
         4'd12:   ch = hex_ascii(c[7:4]);
         4'd13:   ch = hex_ascii(c[3:0]);
         4'd1, 4'd6, 4'd11: ch = ASC_COLON;
         default: ch = ASC_SPACE;
      endcase
      return ch;
   endfunction

   function automatic logic [7:0] line2_char(input logic [3:0] i, input logic [7:0] d,
                                             input logic [2:0] f);
      logic [7:0] ch;
      case (i)
         4'd0:    ch = ASC_D;
         4'd2:    ch = hex_ascii(d[7:4]);
         4'd3:    ch = hex_ascii(d[3:0]);
         4'd5:    ch = ASC_V;
         4'd7:    ch = ASC_0 + {7'h00, f[0]};
         4'd9:    ch = ASC_Z;
         4'd11:   ch = ASC_0 + {7'h00, f[1]};
         4'd13:   ch = ASC_C;
         4'd15:   ch = ASC_0 + {7'h00, f[2]};
         4'd1, 4'd6, 4'd10, 4'd14: ch = ASC_COLON;
         default: ch = ASC_SPACE;
      endcase
      return ch;
   endfunction

   // The byte launched this cycle belongs to the state/index we are moving into,
   // which lets the next SETUP start straight out of the previous HOLD.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wait_nxt  = wait_cnt;
      wr_go     = 1'b0;
      fd_nxt    = 1'b0;
      case (state)
         ST_PWRUP: begin
            if (wait_cnt == PWR_LAST) begin
               state_nxt = ST_INIT;
               idx_nxt   = 4'd0;
               wait_nxt  = '0;
               wr_go     = 1'b1;
            end else begin
               wait_nxt = wait_cnt + CNT_W'(1);
            end
         end
         ST_INIT: begin
            if (wr_done) begin
               if (idx == 4'd3) begin
                  state_nxt = ST_SNAP;
                  idx_nxt   = 4'd0;
               end else begin
                  idx_nxt = idx + 4'd1;
                  wr_go   = 1'b1;
               end
            end
         end
         ST_SNAP: begin
            state_nxt = ST_L1_ADDR;
            wr_go     = 1'b1;
         end
         ST_L1_ADDR, ST_L2_ADDR: begin
            if (wr_done) begin
               state_nxt = (state == ST_L1_ADDR) ? ST_L1_CHARS : ST_L2_CHARS;
               idx_nxt   = 4'd0;
               wr_go     = 1'b1;
            end
         end
         ST_L1_CHARS: begin
            if (wr_done) begin
               wr_go = 1'b1;
               if (idx == 4'd15)
                  state_nxt = ST_L2_ADDR;
               else
                  idx_nxt = idx + 4'd1;
            end
         end
         ST_L2_CHARS: begin
            if (wr_done) begin
               if (idx == 4'd15) begin
                  state_nxt = ST_WAIT;
                  idx_nxt   = 4'd0;
                  wait_nxt  = '0;
                  fd_nxt    = 1'b1;
               end else begin
                  idx_nxt = idx + 4'd1;
                  wr_go   = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == REF_LAST) begin
               state_nxt = ST_SNAP;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_PWRUP;
      endcase
   end

   always_comb begin
      wr_byte = 8'h00;
      wr_rs   = 1'b0;
      case (state_nxt)
         ST_INIT: begin
            case (idx_nxt)
               4'd0:    wr_byte = CMD_FUNC_SET;
               4'd1:    wr_byte = CMD_DISP_ON;
               4'd2:    wr_byte = CMD_CLEAR;
               default: wr_byte = CMD_ENTRY;
            endcase
         end
         ST_L1_ADDR: wr_byte = CMD_LINE1;
         ST_L2_ADDR: wr_byte = CMD_LINE2;
         ST_L1_CHARS: begin
            wr_rs   = 1'b1;
            wr_byte = line1_char(idx_nxt, sh_a, sh_b, sh_c);
         end
         ST_L2_CHARS: begin
            wr_rs   = 1'b1;
            wr_byte = line2_char(idx_nxt, sh_d, sh_flags);
         end
         default: ;
      endcase
   end

   assign long_wait = !wr_rs && (wr_byte == CMD_CLEAR);
   assign wr_start  = wr_go && (!wr_busy || wr_done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_PWRUP;
         idx        <= 4'd0;
         wait_cnt   <= '0;
         frame_done <= 1'b0;
         sh_a       <= 8'h00;
         sh_b       <= 8'h00;
         sh_c       <= 8'h00;
         sh_d       <= 8'h00;
         sh_flags   <= 3'b000;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         wait_cnt   <= wait_nxt;
         frame_done <= fd_nxt;
         if (state == ST_SNAP) begin
            sh_a     <= reg_a;
            sh_b     <= reg_b;
            sh_c     <= reg_c;
            sh_d     <= reg_d;
            sh_flags <= flags[2:0];
         end
      end
   end

   lcd_byte_writer #(
      .E_PULSE_CYC    (E_PULSE_CYC),
      .CMD_WAIT_CYC   (CMD_WAIT_CYC),
      .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
      .CNT_W          (CNT_W)
   ) u_writer (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (wr_start),
      .wr_byte   (wr_byte),
      .wr_rs     (wr_rs),
      .long_wait (long_wait),
      .busy      (wr_busy),
      .done      (wr_done),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_data  (lcd_data)
   );

endmodule

// File: tb/tb_reg_lcd_display.sv
// Bench for reg_lcd_display: records every lcd_e rising edge and checks the byte
// stream, strobe timing and frame_done cadence against a text-level model.
module tb_reg_lcd_display;

   localparam int unsigned P_PWR = 10;
   localparam int unsigned P_EP  = 2;
   localparam int unsigned P_CMD = 4;
   localparam int unsigned P_CLR = 8;
   localparam int unsigned P_REF = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] reg_a, reg_b, reg_c, reg_d, flags;
   logic       lcd_rs, lcd_rw, lcd_e, frame_done;
   logic [7:0] lcd_data;

   always #5 clk = ~clk;

   reg_lcd_display #(
      .POWERUP_CYC    (P_PWR),
      .E_PULSE_CYC    (P_EP),
      .CMD_WAIT_CYC   (P_CMD),
      .CLEAR_WAIT_CYC (P_CLR),
      .REFRESH_CYC    (P_REF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reg_a      (reg_a),
      .reg_b      (reg_b),
      .reg_c      (reg_c),
      .reg_d      (reg_d),
      .flags      (flags),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_e      (lcd_e),
      .lcd_data   (lcd_data),
      .frame_done (frame_done)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus monitor, sampled on the falling edge.
   int         cyc = 0;
   logic       prev_e = 1'b0, prev_fd = 1'b0;
   int         low_lead = 0;
   int         fd_wide = 0;
   int         rise_cyc[$];
   logic [8:0] rise_val[$];
   int         fall_cyc[$];
   int         fd_cyc[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         prev_e   <= 1'b0;
         prev_fd  <= 1'b0;
         low_lead <= 0;
         fd_wide  <= 0;
         rise_cyc.delete();
         rise_val.delete();
         fall_cyc.delete();
         fd_cyc.delete();
      end else begin
         if (lcd_e && !prev_e) begin
            rise_cyc.push_back(cyc);
            rise_val.push_back({lcd_rs, lcd_data});
         end
         if (!lcd_e && prev_e) fall_cyc.push_back(cyc);
         if (!lcd_e && rise_cyc.size() == 0) low_lead <= low_lead + 1;
         if (frame_done) begin
            if (prev_fd) fd_wide <= fd_wide + 1;
            else fd_cyc.push_back(cyc);
         end
         prev_e  <= lcd_e;
         prev_fd <= frame_done;
      end
   end

   // Text-level reference model of one frame.
   function automatic string hx(input logic [7:0] v);
      string digits = "0123456789ABCDEF";
      return $sformatf("%c%c", digits[v[7:4]], digits[v[3:0]]);
   endfunction

   function automatic string bitc(input logic b);
      return b ? "1" : "0";
   endfunction

   function automatic string line1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      return {"A:", hx(a), " B:", hx(b), " C:", hx(c), "  "};
   endfunction

   function automatic string line2(input logic [7:0] d, input logic [7:0] f);
      return {"D:", hx(d), " V:", bitc(f[0]), " Z:", bitc(f[1]), " C:", bitc(f[2])};
   endfunction

   task automatic wait_rises(input int n, input int budget, input string tag);
      int k = 0;
      while (rise_val.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(rise_val.size() >= n), 32'd1);
   endtask

   task automatic wait_fd(input int n, input int budget, input string tag);
      int k = 0;
      while (fd_cyc.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(fd_cyc.size() >= n), 32'd1);
   endtask

   task automatic check_init(input string pfx);
      logic [7:0] ic[4];
      ic[0] = 8'h38; ic[1] = 8'h0C; ic[2] = 8'h01; ic[3] = 8'h06;
      wait_rises(5, 400, {pfx, "_init_timeout"});
      if (rise_val.size() < 5) return;
      chk({pfx, "_lead_low"}, low_lead, P_PWR + 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_init%0d", pfx, i), rise_val[i], {1'b0, ic[i]});
         chk($sformatf("%s_pulse%0d", pfx, i), fall_cyc[i] - rise_cyc[i], P_EP);
      end
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s_gap%0d", pfx, i), rise_cyc[i+1] - fall_cyc[i],
             ((ic[i] == 8'h01) ? P_CLR : P_CMD) + 1);
   endtask

   task automatic check_frame(input int base, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic [7:0] f);
      string l1 = line1(a, b, c);
      string l2 = line2(d, f);
      chk("frame_len", 32'(rise_val.size() >= base + 34), 32'd1);
      if (rise_val.size() < base + 34) return;
      chk("l1_addr", rise_val[base], 9'h080);
      for (int i = 0; i < 16; i++)
         chk($sformatf("l1_ch%0d", i), rise_val[base+1+i], {1'b1, l1[i]});
      chk("l2_addr", rise_val[base+17], 9'h0C0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("l2_ch%0d", i), rise_val[base+18+i], {1'b1, l2[i]});
   endtask

   logic [7:0] ea, eb, ec, ed, ef;
   int         period;
   int         k;

   initial begin
      reg_a = 8'h3C; reg_b = 8'h00; reg_c = 8'hFF; reg_d = 8'hA7; flags = 8'h05;
      repeat (3) @(negedge clk);
      chk("rst_e", lcd_e, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_fd", frame_done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      check_init("first");

      for (int fr = 0; fr < 4; fr++) begin
         ea = reg_a; eb = reg_b; ec = reg_c; ed = reg_d; ef = flags;
         wait_rises(4 + 34*fr + 8, 2000, "midframe_timeout");
         if (fr == 0) begin
            reg_b = 8'h12;
         end else begin
            reg_a = 8'($urandom_range(0, 255));
            reg_b = 8'($urandom_range(0, 255));
            reg_c = 8'($urandom_range(0, 255));
            reg_d = 8'($urandom_range(0, 255));
            flags = 8'($urandom_range(0, 255));
         end
         wait_fd(fr + 1, 2000, "fd_timeout");
         chk("rise_cnt", rise_val.size(), 4 + 34*(fr + 1));
         chk("rw_low", lcd_rw, 0);
         check_frame(4 + 34*fr, ea, eb, ec, ed, ef);
      end

      period = P_REF + 1 + 34 * (1 + P_EP + P_CMD);
      chk("fd_count", fd_cyc.size(), 4);
      chk("fd_wide", fd_wide, 0);
      for (int i = 1; i < fd_cyc.size(); i++)
         chk($sformatf("fd_period%0d", i), fd_cyc[i] - fd_cyc[i-1], period);

      // Reset asserted in the middle of a character strobe.
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(lcd_e && lcd_rs) && k < 2000);
      chk("mid_pulse_found", 32'(lcd_e && lcd_rs), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_e", lcd_e, 0);
      chk("arst_rs", lcd_rs, 0);
      chk("arst_data", lcd_data, 0);
      chk("arst_fd", frame_done, 0);
      repeat (3) @(negedge clk);
      reg_a = 8'($urandom_range(0, 255));
      reg_b = 8'($urandom_range(0, 255));
      reg_c = 8'($urandom_range(0, 255));
      reg_d = 8'($urandom_range(0, 255));
      flags = 8'($urandom_range(0, 255));
      ea = reg_a; eb = reg_b; ec = reg_c; ed = reg_d; ef = flags;
      @(posedge clk);
      #1 rst_n = 1'b1;

      check_init("rerun");
      wait_fd(1, 2000, "rerun_fd_timeout");
      chk("rerun_rise_cnt", rise_val.size(), 4 + 34);
      check_frame(4, ea, eb, ec, ed, ef);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
